axi_mst_initiator: RTL
======================

# axi_mst_initiator

Synthesizable AXI3-style bus master for the crossbar test bench. It turns a simple command port into AW/W/AR bursts. It accepts B and R responses and tracks outstanding transactions. It flags response-ordering and burst-length errors. One instance sits on each crossbar master port, opposite the slave responders.

## Interface
- AXI_ADDR_W, 32, address width
- AXI_ID_W, 4, ID width
- AXI_DATA_W, 32, data width; strobe width is AXI_DATA_W/8
- MST_OSTD_NUM, 4, maximum outstanding writes and maximum outstanding reads, counted separately; must be a power of 2, at least 2
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- srst  in  1  synchronous reset, active-high; same effect as aresetn
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  AXI_ADDR_W  burst start address
- cmd_len  in  4  beats minus 1
- cmd_id  in  AXI_ID_W  transaction ID
- cmd_wdata_base  in  AXI_DATA_W  data for write beat n is base + n, modulo 2^AXI_DATA_W
- bready_en, rready_en  in  1  back-pressure knobs from the bench
- awvalid/awready, awaddr, awlen[4], awsize[3], awburst[2], awid: AW channel; master drives all except awready
- wvalid/wready, wid, wdata, wstrb, wlast: W channel
- bvalid/bready, bid, bresp[2]: B channel
- arvalid/arready, araddr, arlen[4], arsize[3], arburst[2], arid: AR channel
- rvalid/rready, rid, rdata, rresp[2], rlast: R channel
- wr_ostd, rd_ostd  out  $clog2(MST_OSTD_NUM)+1  outstanding counts
- wr_done, rd_done  out  1  one-cycle pulse on B handshake / on R handshake with rlast
- err_id, err_len, err_resp  out  1  sticky error flags; cleared only by reset

## Operation
- **Command acceptance (cmd_ready):**
  - When cmd_write=1: cmd_ready = (wr_state==W_IDLE) && (wr_ostd<MST_OSTD_NUM).
  - When cmd_write=0: cmd_ready = (rd_state==R_IDLE) && (rd_ostd<MST_OSTD_NUM).
  - cmd_ready is combinational on cmd_write.
- **Write FSM:**
  - W_IDLE to W_ADDR on acceptance. Latch addr/len/id/base, push {id,len} into the write tracker, increment wr_ostd.
  - W_ADDR to W_DATA on awvalid&&awready.
  - W_DATA sends awlen+1 beats; wlast is asserted on beat index == awlen. W_DATA to W_IDLE on the wlast handshake.
- **Read FSM:**
  - R_IDLE to R_ADDR on acceptance. Push {id,len} into the read tracker, increment rd_ostd.
  - R_ADDR to R_IDLE on arvalid&&arready.
- **Fixed fields:** awsize = arsize = $clog2(AXI_DATA_W/8); awburst = arburst = INCR (2'b01); wstrb all ones; wid = latched id.
- **B response:**
  - bready = bready_en.
  - On handshake: pop the write tracker and decrement wr_ostd.
  - err_id if bid != head id. err_resp if bresp != OKAY.
- **R response:**
  - rready = rready_en.
  - Beat counter (4 bits) increments per handshake and clears on rlast.
  - err_len if rlast != (beat==head len).
  - err_id if rid != head id.
  - err_resp if rresp != OKAY.
  - On the rlast handshake: pop, decrement rd_ostd, pulse rd_done.
- **Ordering:** trackers are in-order; responses are expected in issue order per direction.
- **Spurious responses:** a bvalid/rvalid handshake with an empty tracker sets err_id and changes no counter or pointer.
- **Simultaneous events:** accept and pop in the same cycle leave the count unchanged.

## Timing
- **Reset values:** all valids 0, all payloads 0, wlast 0, counters 0, trackers empty, FSMs idle, errors 0, done pulses 0.
- awvalid/arvalid rise the cycle after acceptance. wvalid rises the cycle after the AW handshake.
- Back-to-back W beats when wready is held high: 1 beat/cycle.
- Once asserted, a valid and its payload are held stable until the handshake. A valid never depends on the corresponding ready.
- Minimum write command-to-command spacing: 3 cycles (accept, AW, one W beat). Read spacing: 2 cycles.
- Reset mid-operation, asynchronous or srst: everything returns to reset values immediately (async) or next edge (srst). In-flight bursts are abandoned.
- Tracker full is impossible by construction: acceptance is gated on ostd<MST_OSTD_NUM. Pointers wrap modulo MST_OSTD_NUM.

## Structure
- **Package axi_tb_pkg:**
  - Width localparams: AXI_LEN_W=4, AXI_SIZE_W=3, AXI_BURST_W=2, AXI_RESP_W=2.
  - Burst constants (FIXED/INCR/WRAP) and resp constants (OKAY/EXOKAY/SLVERR/DECERR).
  - State enums wr_state_e {W_IDLE,W_ADDR,W_DATA} and rd_state_e {R_IDLE,R_ADDR}.
- **Sub-module axi_ostd_fifo:** parameterized depth and width, async+sync reset, push/pop/head/count outputs. Instantiated twice, for the write and read trackers.

## Test plan
- Write cmd id=3 len=3 base=0x100 with awready/wready held 1: AW one cycle after accept; 4 W beats 0x100..0x103 on consecutive cycles with wlast on the 4th; bid=3 OKAY gives wr_done, wr_ostd 1→0, no errors.
- Read len=0 id=5: single R beat with rlast=1, rid=5 gives rd_done. The same beat with rlast=0 sets err_len.
- 4 reads issued with rvalid held 0: rd_ostd=4, cmd_ready=0 for a read command. A read command is accepted again in the cycle rd_ostd drops to 3.
- Responder returns bid=2 while the tracker head is 1: err_id=1 stays set. A bresp=SLVERR sets err_resp.
- awready held 0 for 5 cycles: awvalid and awaddr are stable for all 5 cycles. Same-cycle R-last pop and read acceptance leave rd_ostd unchanged.
- Assert srst in the middle of a W burst: next edge wvalid=0, wr_ostd=0, FSM in W_IDLE. A new command is accepted the following cycle.

Source files
------------

// File: rtl/axi_tb_pkg.sv
// rtl/axi_tb_pkg.sv - shared widths, AXI encodings and FSM states for the crossbar bench master
package axi_tb_pkg;

    localparam int AXI_LEN_W   = 4;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;

    localparam logic [AXI_BURST_W-1:0] BURST_FIXED = 2'b00;
    localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = 2'b10;

    localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_ADDR
    } rd_state_e;

endpackage

// File: rtl/axi_ostd_fifo.sv
// rtl/axi_ostd_fifo.sv - in-order tracker of outstanding bursts, head visible combinationally
module axi_ostd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     srst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_mst_initiator.sv
// rtl/axi_mst_initiator.sv - command-driven AXI3 burst master with in-order response checking
module axi_mst_initiator
    import axi_tb_pkg::*;
#(
    parameter int AXI_ADDR_W   = 32,
    parameter int AXI_ID_W     = 4,
    parameter int AXI_DATA_W   = 32,
    parameter int MST_OSTD_NUM = 4
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          srst,

    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [AXI_ADDR_W-1:0]         cmd_addr,
    input  logic [3:0]                    cmd_len,
    input  logic [AXI_ID_W-1:0]           cmd_id,
    input  logic [AXI_DATA_W-1:0]         cmd_wdata_base,
    input  logic                          bready_en,
    input  logic                          rready_en,

    output logic                          awvalid,
    input  logic                          awready,
    output logic [AXI_ADDR_W-1:0]         awaddr,
    output logic [3:0]                    awlen,
    output logic [2:0]                    awsize,
    output logic [1:0]                    awburst,
    output logic [AXI_ID_W-1:0]           awid,

    output logic                          wvalid,
    input  logic                          wready,
    output logic [AXI_ID_W-1:0]           wid,
    output logic [AXI_DATA_W-1:0]         wdata,
    output logic [AXI_DATA_W/8-1:0]       wstrb,
    output logic                          wlast,

    input  logic                          bvalid,
    output logic                          bready,
    input  logic [AXI_ID_W-1:0]           bid,
    input  logic [1:0]                    bresp,

    output logic                          arvalid,
    input  logic                          arready,
    output logic [AXI_ADDR_W-1:0]         araddr,
    output logic [3:0]                    arlen,
    output logic [2:0]                    arsize,
    output logic [1:0]                    arburst,
    output logic [AXI_ID_W-1:0]           arid,

    input  logic                          rvalid,
    output logic                          rready,
    input  logic [AXI_ID_W-1:0]           rid,
    input  logic [AXI_DATA_W-1:0]         rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rlast,

    output logic [$clog2(MST_OSTD_NUM):0] wr_ostd,
    output logic [$clog2(MST_OSTD_NUM):0] rd_ostd,
    output logic                          wr_done,
    output logic                          rd_done,
    output logic                          err_id,
    output logic                          err_len,
    output logic                          err_resp
);

    localparam int STRB_W = AXI_DATA_W / 8;
    localparam int TRK_W  = AXI_ID_W + AXI_LEN_W;
    localparam logic [AXI_SIZE_W-1:0] BEAT_SIZE = AXI_SIZE_W'($clog2(STRB_W));

    wr_state_e wr_state, wr_state_nxt;
    rd_state_e rd_state, rd_state_nxt;

    logic                  wr_full, wr_empty, rd_full, rd_empty;
    logic [TRK_W-1:0]      wr_head, rd_head;
    logic [AXI_ID_W-1:0]   wr_head_id, rd_head_id;
    logic [AXI_LEN_W-1:0]  rd_head_len, wr_head_len_unused;
    logic                  wr_accept, rd_accept;
    logic                  aw_hs, w_hs, ar_hs, b_hs, r_hs, wr_pop, rd_pop;

    logic [AXI_ADDR_W-1:0] aw_addr_q, ar_addr_q;
    logic [AXI_LEN_W-1:0]  aw_len_q, ar_len_q, w_beat_q, r_beat_q;
    logic [AXI_ID_W-1:0]   aw_id_q, ar_id_q;
    logic [AXI_DATA_W-1:0] w_base_q;
    logic                  rdata_unused;

    assign rdata_unused = ^rdata;

    assign cmd_ready = cmd_write ? ((wr_state == W_IDLE) && !wr_full)
                                 : ((rd_state == R_IDLE) && !rd_full);
    assign wr_accept = cmd_valid && cmd_ready && cmd_write;
    assign rd_accept = cmd_valid && cmd_ready && !cmd_write;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    assign bready = bready_en;
    assign rready = rready_en;
    assign b_hs   = bvalid && bready;
    assign r_hs   = rvalid && rready;

    // A response with nothing outstanding is flagged but must not disturb the trackers.
    assign wr_pop = b_hs && !wr_empty;
    assign rd_pop = r_hs && rlast && !rd_empty;

    assign wr_done = wr_pop;
    assign rd_done = rd_pop;

    assign {wr_head_id, wr_head_len_unused} = wr_head;
    assign {rd_head_id, rd_head_len}        = rd_head;

    axi_ostd_fifo #(
        .DEPTH (MST_OSTD_NUM),
        .WIDTH (TRK_W)
    ) u_wr_trk (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .srst      (srst),
        .push      (wr_accept),
        .push_data ({cmd_id, cmd_len}),
        .pop       (wr_pop),
        .head      (wr_head),
        .count     (wr_ostd),
        .empty     (wr_empty),
        .full      (wr_full)
    );

    axi_ostd_fifo #(
        .DEPTH (MST_OSTD_NUM),
        .WIDTH (TRK_W)
    ) u_rd_trk (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .srst      (srst),
        .push      (rd_accept),
        .push_data ({cmd_id, cmd_len}),
        .pop       (rd_pop),
        .head      (rd_head),
        .count     (rd_ostd),
        .empty     (rd_empty),
        .full      (rd_full)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else if (srst) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
        end
    end

    always_comb begin
        wr_state_nxt = wr_state;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        wlast        = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (wr_accept) wr_state_nxt = W_ADDR;
            end
            W_ADDR: begin
                awvalid = 1'b1;
                if (aw_hs) wr_state_nxt = W_DATA;
            end
            W_DATA: begin
                wvalid = 1'b1;
                wlast  = (w_beat_q == aw_len_q);
                if (w_hs && wlast) wr_state_nxt = W_IDLE;
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_nxt = rd_state;
        arvalid      = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (rd_accept) rd_state_nxt = R_ADDR;
            end
            R_ADDR: begin
                arvalid = 1'b1;
                if (ar_hs) rd_state_nxt = R_IDLE;
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    assign awaddr  = aw_addr_q;
    assign awlen   = aw_len_q;
    assign awid    = aw_id_q;
    assign awsize  = BEAT_SIZE;
    assign awburst = BURST_INCR;
    assign wid     = aw_id_q;
    assign wstrb   = '1;
    assign wdata   = w_base_q + AXI_DATA_W'(w_beat_q);
    assign araddr  = ar_addr_q;
    assign arlen   = ar_len_q;
    assign arid    = ar_id_q;
    assign arsize  = BEAT_SIZE;
    assign arburst = BURST_INCR;

    // Payload registers are only loaded on acceptance, so they stay stable until the handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_addr_q <= '0; aw_len_q <= '0; aw_id_q <= '0; w_base_q <= '0; w_beat_q <= '0;
            ar_addr_q <= '0; ar_len_q <= '0; ar_id_q <= '0;
        end else if (srst) begin
            aw_addr_q <= '0; aw_len_q <= '0; aw_id_q <= '0; w_base_q <= '0; w_beat_q <= '0;
            ar_addr_q <= '0; ar_len_q <= '0; ar_id_q <= '0;
        end else begin
            if (wr_accept) begin
                aw_addr_q <= cmd_addr;
                aw_len_q  <= cmd_len;
                aw_id_q   <= cmd_id;
                w_base_q  <= cmd_wdata_base;
                w_beat_q  <= '0;
            end else if (w_hs) begin
                w_beat_q  <= w_beat_q + 1'b1;
            end
            if (rd_accept) begin
                ar_addr_q <= cmd_addr;
                ar_len_q  <= cmd_len;
                ar_id_q   <= cmd_id;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_beat_q <= '0;
            err_id   <= 1'b0;
            err_len  <= 1'b0;
            err_resp <= 1'b0;
        end else if (srst) begin
            r_beat_q <= '0;
            err_id   <= 1'b0;
            err_len  <= 1'b0;
            err_resp <= 1'b0;
        end else begin
            if (r_hs && !rd_empty) begin
                r_beat_q <= rlast ? '0 : r_beat_q + 1'b1;
            end
            if ((b_hs && (wr_empty || bid != wr_head_id)) ||
                (r_hs && (rd_empty || rid != rd_head_id))) begin
                err_id <= 1'b1;
            end
            if (r_hs && !rd_empty && (rlast != (r_beat_q == rd_head_len))) begin
                err_len <= 1'b1;
            end
            if ((b_hs && bresp != RESP_OKAY) || (r_hs && rresp != RESP_OKAY)) begin
                err_resp <= 1'b1;
            end
        end
    end

endmodule
